// File: rtl/eth_sw_pkg.sv
// Shared types for the eth_sw ingress path.
// Latency: n/a (types only).
// Backpressure: n/a.
package eth_sw_pkg;

    localparam int DATA_W_DEF = 32;

    // Layout of one buffer RAM entry.
    typedef struct packed {
        logic                  eop;
        logic [DATA_W_DEF-1:0] data;
    } buf_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } wr_state_t;

endpackage

// File: rtl/eth_sw_buf_ram.sv
// Simple dual-port buffer RAM with synchronous write and synchronous, enabled read.
// Latency: read data valid one cycle after re.
// Backpressure: none; the registered read port holds its value while re is low.
module eth_sw_buf_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the block's output register, so it is reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eth_sw_ingress_buf.sv
// Per-port store-and-forward ingress buffer: releases only complete packets, drops ones that do not fit.
// Latency: end word written at edge k, first word of that packet presented after edge k+1.
// Backpressure: none upstream (overflow drops the packet); downstream stall freezes all outputs.
module eth_sw_ingress_buf
    import eth_sw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_valid,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_start,
    input  logic                   i_end,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_start,
    output logic                   o_end,
    input  logic                   stall,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wr_state_t     state, state_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr;
    logic [PW-1:0] base, fill;
    logic          we, drop, load, seen_word;
    logic [DATA_W:0] rdata;

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        we          = 1'b0;
        drop        = 1'b0;
        base        = wr_ptr;
        fill        = wr_ptr - rd_ptr;
        if (i_valid) begin
            if (i_start) begin
                // A start mid-packet abandons the tentative words and rewrites from the commit point.
                if (state == RECV) begin
                    drop = 1'b1;
                    base = wr_commit;
                end
                fill = base - rd_ptr;
                if (fill == PW'(DEPTH)) begin
                    drop     = 1'b1;
                    wr_ptr_n = wr_commit;
                    state_n  = i_end ? IDLE : DISCARD;
                end else begin
                    we       = 1'b1;
                    wr_ptr_n = base + PW'(1);
                    if (i_end) begin
                        wr_commit_n = base + PW'(1);
                        state_n     = IDLE;
                    end else begin
                        state_n = RECV;
                    end
                end
            end else if (state == RECV) begin
                if (fill == PW'(DEPTH)) begin
                    drop     = 1'b1;
                    wr_ptr_n = wr_commit;
                    state_n  = i_end ? IDLE : DISCARD;
                end else begin
                    we       = 1'b1;
                    wr_ptr_n = wr_ptr + PW'(1);
                    if (i_end) begin
                        wr_commit_n = wr_ptr + PW'(1);
                        state_n     = IDLE;
                    end
                end
            end else if (state == DISCARD && i_end) begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            wr_commit  <= wr_commit_n;
            drop_pulse <= drop;
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign load = (rd_ptr != wr_commit) && (!o_valid || !stall);

    eth_sw_buf_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we),
        .waddr (base[AW-1:0]),
        .wdata ({i_end, i_data}),
        .re    (load),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // rdata still holds the previously loaded word when the next load is decided.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr    <= '0;
            o_valid   <= 1'b0;
            o_start   <= 1'b0;
            seen_word <= 1'b0;
        end else if (load) begin
            rd_ptr    <= rd_ptr + PW'(1);
            o_valid   <= 1'b1;
            o_start   <= !seen_word || rdata[DATA_W];
            seen_word <= 1'b1;
        end else if (!stall) begin
            o_valid <= 1'b0;
        end
    end

    assign o_data = rdata[DATA_W-1:0];
    assign o_end  = rdata[DATA_W];
    assign level  = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_eth_sw_ingress_buf.sv
// Directed bench for eth_sw_ingress_buf with DEPTH=8: streaming, stall, overflow, abort, orphans, reset.
module tb_eth_sw_ingress_buf;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_start = 1'b0;
    logic        i_end = 1'b0;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_start;
    logic        o_end;
    logic        stall = 1'b0;
    logic        drop_pulse;
    logic [15:0] drop_cnt;
    logic [3:0]  level;

    int total = 0;
    int bad = 0;
    int npulse = 0;
    logic [33:0] got [$];

    eth_sw_ingress_buf #(
        .DATA_W (32),
        .DEPTH  (8),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_start    (i_start),
        .i_end      (i_end),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_start    (o_start),
        .o_end      (o_end),
        .stall      (stall),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Record every word the switch actually takes, plus drop pulses.
    always @(negedge clk) begin
        if (o_valid && !stall) got.push_back({o_start, o_end, o_data});
        if (drop_pulse) npulse++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic s, input logic e, input logic [31:0] d);
        return {s, e, d};
    endfunction

    task automatic send(input logic s, input logic e, input logic [31:0] d);
        i_valid = 1'b1;
        i_start = s;
        i_end   = e;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_start = 1'b0;
        i_end   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0;
        rstn  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        npulse = 0;
    endtask

    task automatic expect_pkt(input string tag, input logic [33:0] exp [$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
        end
    endtask

    initial begin
        logic [33:0] e [$];

        #12;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_start_end", {o_start, o_end}, 0);
        check("rst_drop", {drop_pulse, drop_cnt}, 0);
        check("rst_level", level, 0);
        rstn = 1'b1;

        // Plain 4-word packet and its latency.
        do_reset();
        send(1, 0, 32'hA0);
        send(0, 0, 32'hA1);
        send(0, 0, 32'hA2);
        check("t1_level_tentative", level, 3);
        send(0, 1, 32'hA3);
        check("t1_level_committed", level, 4);
        check("t1_not_yet_valid", o_valid, 0);
        tick(1);
        check("t1_first_out", {o_valid, o_start, o_data}, {1'b1, 1'b1, 32'hA0});
        tick(8);
        e = '{mk(1, 0, 32'hA0), mk(0, 0, 32'hA1), mk(0, 0, 32'hA2), mk(0, 1, 32'hA3)};
        expect_pkt("t1", e);
        check("t1_level_end", level, 0);

        // Stall while A1 is presented.
        do_reset();
        send(1, 0, 32'hA0);
        send(0, 0, 32'hA1);
        send(0, 0, 32'hA2);
        send(0, 1, 32'hA3);
        tick(1);
        tick(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t2_hold%0d", i), {o_valid, o_start, o_end, o_data}, {3'b100, 32'hA1});
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        tick(8);
        expect_pkt("t2", e);

        // 10-word packet overflows the 8-deep buffer, then B fits.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(i == 0, i == 9, 32'hC00 + i);
            if (i == 7) check("t3_level_full", level, 8);
            if (i == 8) check("t3_overflow", {drop_pulse, level}, {1'b1, 4'd0});
        end
        send(1, 0, 32'hB0);
        send(0, 0, 32'hB1);
        send(0, 1, 32'hB2);
        tick(8);
        e = '{mk(1, 0, 32'hB0), mk(0, 0, 32'hB1), mk(0, 1, 32'hB2)};
        expect_pkt("t3", e);
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_pulses", npulse, 1);
        check("t3_level_end", level, 0);

        // Restart mid-packet aborts P, Q passes intact.
        do_reset();
        send(1, 0, 32'hD0);
        send(0, 0, 32'hD1);
        send(0, 0, 32'hD2);
        send(1, 0, 32'hE0);
        check("t4_abort_pulse", drop_pulse, 1);
        send(0, 1, 32'hE1);
        check("t4_pulse_once", drop_pulse, 0);
        tick(8);
        e = '{mk(1, 0, 32'hE0), mk(0, 1, 32'hE1)};
        expect_pkt("t4", e);
        check("t4_drop_cnt", drop_cnt, 1);

        // Single-word packet, orphans, then a 2-word packet.
        do_reset();
        send(1, 1, 32'h55);
        send(0, 0, 32'h66);
        send(0, 1, 32'h77);
        check("t5_orphans_ignored", level, 0);
        send(1, 0, 32'h88);
        send(0, 1, 32'h99);
        tick(8);
        e = '{mk(1, 1, 32'h55), mk(1, 0, 32'h88), mk(0, 1, 32'h99)};
        expect_pkt("t5", e);
        check("t5_drop_cnt", drop_cnt, 0);

        // Asynchronous reset mid-packet under stall.
        do_reset();
        stall = 1'b1;
        send(1, 0, 32'hF0);
        send(0, 1, 32'hF1);
        tick(2);
        check("t6_held", {o_valid, o_start, o_data}, {1'b1, 1'b1, 32'hF0});
        send(1, 0, 32'h10);
        send(0, 0, 32'h11);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_out", {o_valid, o_start, o_end, o_data}, 0);
        check("t6_async_level", level, 0);
        @(negedge clk);
        rstn  = 1'b1;
        stall = 1'b0;
        tick(1);
        got.delete();
        send(1, 0, 32'h20);
        send(0, 1, 32'h21);
        tick(8);
        e = '{mk(1, 0, 32'h20), mk(0, 1, 32'h21)};
        expect_pkt("t6", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_sw_ingress_buf.md
Name: eth_sw_ingress_buf

Overview:
- Per-port ingress store-and-forward packet buffer. One instance sits directly upstream of each eth_sw input port.
- Accepts a non-stallable word stream from the MAC side and releases only complete packets to the switch.
- Honours the switch's per-port stall backpressure.
- Drops a packet that does not fit the buffer, and counts the drop.

Parameters:
- DATA_W, 32, packet data word width.
- DEPTH, 64, buffer depth in words; must be a power of 2, minimum 4.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, active low
- i_valid  input  1  MAC word valid; there is no upstream backpressure
- i_data  input  DATA_W  MAC data word
- i_start  input  1  first word of packet; qualified by i_valid
- i_end  input  1  last word of packet; qualified by i_valid
- o_valid  output  1  word presented to the switch
- o_data  output  DATA_W  to eth_sw i_data
- o_start  output  1  to eth_sw i_start; qualified by o_valid
- o_end  output  1  to eth_sw i_end; qualified by o_valid
- stall  input  1  from eth_sw stall; presented word is not consumed while high
- drop_pulse  output  1  one-cycle pulse per dropped or aborted packet
- drop_cnt  output  CNT_W  saturating dropped-packet count
- level  output  $clog2(DEPTH)+1  words held in RAM, committed plus tentative

Behaviour:
- Single clock clk. Reset rstn is asynchronous, active-low. All flops are cleared on assertion.
- Reset values:
  - o_valid=0, o_start=0, o_end=0, o_data=0.
  - drop_pulse=0, drop_cnt=0, level=0.
  - All pointers = 0; write FSM in IDLE.
- Storage:
  - Each entry is {end flag, data}.
  - Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - Full when wr_ptr - rd_ptr == DEPTH.
- Write FSM, states IDLE and RECV:
  - IDLE, i_valid & i_start & !full: write the word, wr_ptr++. Go to RECV, unless i_end is also high; a single-word packet commits immediately.
  - IDLE, i_valid & !i_start: word is discarded silently (orphan). No drop count.
  - RECV, i_valid & !i_start & !full: write, wr_ptr++. If i_end: wr_commit <= wr_ptr+1 and go to IDLE.
  - RECV, i_valid & i_start (new start before end): abort the current packet.
    - wr_ptr <= wr_commit, drop_pulse=1, drop_cnt++.
    - The new word is then handled as an IDLE start in the same cycle, writing at the rolled-back address.
  - Any state, i_valid & full: packet overflow.
    - wr_ptr <= wr_commit, drop_pulse=1, drop_cnt++. Go to DISCARD.
  - DISCARD: ignore words until i_valid & i_end, then go to IDLE. An i_start in DISCARD restarts reception as in IDLE.
- Commit: wr_commit advances at the same edge the end word is written.
- drop_cnt saturates at all-ones. drop_pulse lasts one cycle per event.
- Read side:
  - One output register. It loads from RAM when rd_ptr != wr_commit and (!o_valid or !stall).
  - rd_ptr increments on each load.
  - o_start=1 on the first word loaded after a word with end flag set (or after reset). o_end = stored end flag.
  - While o_valid & stall, all outputs hold stable.
  - Back-to-back packets stream with no idle cycle.
- Latency: end word written at edge k → first word of that packet on outputs after edge k+1. o_valid is high in the cycle after the i_end cycle plus one.
- Simultaneous read and write in the same cycle are both permitted. level reflects both.
- Uncommitted words are never visible to the read side. The read side never reads past wr_commit.
- A packet longer than DEPTH is always dropped.

Decomposition:
- eth_sw_pkg holds:
  - DATA_W default;
  - buf_word_t struct {logic eop; logic [DATA_W-1:0] data};
  - the write-FSM state enum (IDLE, RECV, DISCARD).
- Sub-module eth_sw_buf_ram: simple dual-port RAM with synchronous write and synchronous read, DEPTH x (DATA_W+1), sharing clk.
- FSM, pointers and output register live in eth_sw_ingress_buf.

Test Plan:
- 4-word packet A0..A3, stall=0 → o_valid sequence A0(start)..A3(end), first output two cycles after the i_end cycle; level returns to 0.
- Same packet with stall held high for 3 cycles while A1 is presented → A1 stable for 4 cycles, then A2, A3; no word lost or duplicated.
- DEPTH=8: 10-word packet, then a 3-word packet B → drop_pulse once, drop_cnt=1, only B0..B2 emitted, level=0 at the end.
- Start at word 3 of an unfinished packet P, followed by a 2-word packet Q → P aborted (drop_cnt=1), Q emitted intact with o_start on Q0.
- Single-word packet (start & end together), then orphan words with no start, then a 2-word packet → single word emitted with o_start=o_end=1; orphans ignored; drop_cnt=0.
- rstn asserted mid-packet with stall high → outputs zero immediately (asynchronous); after release, a new 2-word packet passes normally.
